// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder. One full-adder cell, built
// from two half adders plus an OR, is reused over WIDTH cycles, LSB first.
//
// Optional build macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. When it is
// set, B is latched inverted and the carry starts at 1, so the result is
// a - b. In that case cout=1 means no borrow occurred.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   start  request, sampled only in IDLE or DONE
//   a, b   operands, latched on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) subtract select, latched with operands
//   busy   high while the serial add is running
//   done   one-cycle pulse when sum/cout become valid
//   sum    result, held until the next completion
//   cout   carry out of the MSB, held with sum

// half_adder: combinational 1-bit half adder.
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum_c,
  output logic carry_c
);
  assign sum_c   = x ^ y;
  assign carry_c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sh_a, sh_a_n;
  logic [WIDTH-1:0]   sh_b, sh_b_n;
  logic               carry, carry_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  // Holds the bits already produced. They enter at the MSB end, so after
  // WIDTH-1 cycles bit 0 of the result sits in res[0].
  logic [RES_W-1:0]   res, res_n;
  logic               busy_n, done_n, cout_n;
  logic [WIDTH-1:0]   sum_n;

  logic               cell_s1, cell_c1, cell_s, cell_c2;
  logic               init_carry_c;
  logic [WIDTH-1:0]   load_b_c;

  // Shared full-adder cell: two half adders plus an OR for the carry.
  half_adder u_ha0 (
    .x       (sh_a[0]),
    .y       (sh_b[0]),
    .sum_c   (cell_s1),
    .carry_c (cell_c1)
  );

  half_adder u_ha1 (
    .x       (cell_s1),
    .y       (carry),
    .sum_c   (cell_s),
    .carry_c (cell_c2)
  );

  // Operand B and initial carry at load time: inverted B plus a carry-in of 1
  // turns the adder into a subtractor.
`ifdef SERIAL_ADDER_SUB_EN
  assign init_carry_c = sub;
  assign load_b_c     = sub ? ~b : b;
`else
  assign init_carry_c = 1'b0;
  assign load_b_c     = b;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_n;
      sh_a  <= sh_a_n;
      sh_b  <= sh_b_n;
      carry <= carry_n;
      cnt   <= cnt_n;
      res   <= res_n;
      busy  <= busy_n;
      done  <= done_n;
      sum   <= sum_n;
      cout  <= cout_n;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_n = state;
    sh_a_n  = sh_a;
    sh_b_n  = sh_b;
    carry_n = carry;
    cnt_n   = cnt;
    res_n   = res;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    sum_n   = sum;
    cout_n  = cout;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sh_a_n  = a;
          sh_b_n  = load_b_c;
          carry_n = init_carry_c;
          cnt_n   = '0;
          res_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        busy_n  = 1'b1;
        carry_n = cell_c1 | cell_c2;
        sh_a_n  = sh_a >> 1;
        sh_b_n  = sh_b >> 1;
        res_n   = RES_W'({cell_s, res} >> 1);
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          sum_n   = {cell_s, res};
          cout_n  = cell_c1 | cell_c2;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
